// File: rtl/div_engine_if.sv
// div_engine_if
// Groups the request / response signals of the iterative divider.
//   start_i       request strobe, sampled only while the divider is idle
//   dividend_i    rs1 operand
//   divisor_i     rs2 operand
//   op_i          funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU
//   reg_waddr_i   destination register index carried with the request
//   flush_i       cancels the operation in flight
//   busy_o        high while an operation is in flight
//   ready_o       one-cycle pulse, result_o / reg_waddr_o valid
//   result_o      quotient or remainder
//   reg_waddr_o   destination register index for the write-back
// The master modport is the requester (pipeline); the slave is the divider.
interface div_engine_if;
    logic        start_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [2:0]  op_i;
    logic [4:0]  reg_waddr_i;
    logic        flush_i;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] result_o;
    logic [4:0]  reg_waddr_o;

    modport master (
        output start_i, dividend_i, divisor_i, op_i, reg_waddr_i, flush_i,
        input  busy_o, ready_o, result_o, reg_waddr_o
    );

    modport slave (
        input  start_i, dividend_i, divisor_i, op_i, reg_waddr_i, flush_i,
        output busy_o, ready_o, result_o, reg_waddr_o
    );
endinterface

// File: rtl/div_engine.sv
// div_engine
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU. Restoring division,
// one quotient bit per cycle, MSB first.
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  div_engine_if.slave: request operands/strobe/flush in, result out
// Timeline: the accepting edge moves IDLE->START, the next edge START->CALC
// (or straight to END for a zero divisor), CALC runs 32 cycles, END pulses
// ready_o for one cycle and returns to IDLE.
module div_engine (
    input  logic        clk,
    input  logic        rst,
    div_engine_if.slave bus
);

    typedef enum logic [1:0] {IDLE, START, CALC, END} state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] dividend_q;
    logic [31:0] divisor_q;
    logic [31:0] rem_q;
    logic [31:0] result_q;
    logic [2:0]  op_q;
    logic [4:0]  waddr_q;
    logic [4:0]  waddr_out_q;
    logic [5:0]  count_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic        is_signed;
    logic [32:0] rem_shift;
    logic [32:0] diff;
    logic        q_bit;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_final;
    logic [31:0] rem_final;

    // op[1] selects remainder; op[0] clear means a signed operation.
    assign is_signed = op_q[2] & ~op_q[0];

    // One restoring step. The quotient builds up in the dividend register as
    // dividend bits shift out of its MSB into the partial remainder. The
    // partial remainder is always below the divisor, so 33 bits suffice and
    // diff[32] is the borrow.
    always_comb begin
        rem_shift = {rem_q, dividend_q[31]};
        diff      = rem_shift - {1'b0, divisor_q};
        q_bit     = ~diff[32];
        rem_step  = q_bit ? diff[31:0] : rem_shift[31:0];
        quo_step  = {dividend_q[30:0], q_bit};
        quo_final = neg_quo_q ? -quo_step : quo_step;
        rem_final = neg_rem_q ? -rem_step : rem_step;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Flush beats everything, including a start in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.start_i && !bus.flush_i) state_next = START;
            START: begin
                if (bus.flush_i)          state_next = IDLE;
                else if (divisor_q == '0) state_next = END;
                else                      state_next = CALC;
            end
            CALC: begin
                if (bus.flush_i)               state_next = IDLE;
                else if (count_q == 6'd31)     state_next = END;
            end
            END:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. Results are only written on the edge that enters END, so a
    // flush (which steers away from END) leaves the previous result intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dividend_q  <= '0;
            divisor_q   <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            op_q        <= '0;
            waddr_q     <= '0;
            waddr_out_q <= '0;
            count_q     <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (state_next == START) begin
                        dividend_q <= bus.dividend_i;
                        divisor_q  <= bus.divisor_i;
                        op_q       <= bus.op_i;
                        waddr_q    <= bus.reg_waddr_i;
                    end
                end
                START: begin
                    count_q   <= '0;
                    rem_q     <= '0;
                    neg_quo_q <= is_signed & ~op_q[1] & (dividend_q[31] ^ divisor_q[31]);
                    neg_rem_q <= is_signed & op_q[1] & dividend_q[31];
                    if (is_signed && dividend_q[31]) dividend_q <= -dividend_q;
                    if (is_signed && divisor_q[31])  divisor_q  <= -divisor_q;
                    // Zero divisor: quotient all ones, remainder is the raw dividend.
                    if (state_next == END) begin
                        result_q    <= op_q[1] ? dividend_q : 32'hFFFF_FFFF;
                        waddr_out_q <= waddr_q;
                    end
                end
                CALC: begin
                    dividend_q <= quo_step;
                    rem_q      <= rem_step;
                    count_q    <= count_q + 6'd1;
                    if (state_next == END) begin
                        result_q    <= op_q[1] ? rem_final : quo_final;
                        waddr_out_q <= waddr_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o      = (state != IDLE);
    assign bus.ready_o     = (state == END) && !bus.flush_i;
    assign bus.result_o    = result_q;
    assign bus.reg_waddr_o = waddr_out_q;

endmodule

// File: tb/tb_div_engine.sv
// tb_div_engine
// Directed bench for div_engine. Expected results come from a reference
// model built on SV arithmetic, are pushed to a scoreboard queue when a
// request is issued and popped when ready_o is seen. Edges are counted with
// the accepting edge as edge 1.
module tb_div_engine;

    logic clk;
    logic rst;

    div_engine_if bus ();

    div_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] result;
        logic [4:0]  waddr;
        int          latency;
    } exp_t;

    exp_t        sb[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          failCount  = 0;
    logic [31:0] lastResult = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] modelResult(input logic [2:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b);
        logic overflow;
        overflow = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            3'b100:  return overflow ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'b101:  return a / b;
            3'b110:  return overflow ? 32'd0 : 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a one-cycle request; caller must be positioned at a negedge.
    // Returns just after the accepting edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] w,
                                 input bit expectResult);
        exp_t e;
        if (expectResult) begin
            e.result  = modelResult(op, a, b);
            e.waddr   = w;
            e.latency = (b == 32'd0) ? 2 : 34;
            sb.push_back(e);
        end
        bus.start_i     = 1'b1;
        bus.op_i        = op;
        bus.dividend_i  = a;
        bus.divisor_i   = b;
        bus.reg_waddr_i = w;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
    endtask

    // Waits for ready_o (bounded), compares against the scoreboard head and
    // checks the one-cycle pulse and result hold. If pokeEdge is nonzero, a
    // foreign request is pulsed at that edge count and must be ignored.
    // Leaves the caller at the negedge after the ready cycle.
    task automatic waitResult(input int pokeEdge);
        exp_t        e;
        int          edges;
        bit          seen;
        logic [31:0] held;
        edges = 1;
        seen  = 0;
        while (edges <= 100) begin
            @(negedge clk);
            if (edges == 1) checkOutput("busy_in_flight", 32'(bus.busy_o), 32'd1);
            if (pokeEdge != 0 && edges == pokeEdge) begin
                bus.start_i     = 1'b1;
                bus.op_i        = 3'b101;
                bus.dividend_i  = 32'd77;
                bus.divisor_i   = 32'd11;
                bus.reg_waddr_i = 5'd31;
            end else if (edges == pokeEdge + 1) begin
                bus.start_i = 1'b0;
            end
            if (bus.ready_o) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            edges++;
        end
        bus.start_i = 1'b0;
        checkOutput("ready_seen", 32'(seen), 32'd1);
        if (sb.size() == 0) begin
            checkOutput("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (seen) begin
                checkOutput("latency", 32'(edges), 32'(e.latency));
                checkOutput("result", bus.result_o, e.result);
                checkOutput("waddr", 32'(bus.reg_waddr_o), 32'(e.waddr));
                lastResult = e.result;
                held = bus.result_o;
                @(negedge clk);
                checkOutput("ready_one_cycle", 32'(bus.ready_o), 32'd0);
                checkOutput("result_hold", bus.result_o, held);
            end
        end
    endtask

    initial begin
        int pulses;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;

        bus.start_i     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.op_i        = 3'b100;
        bus.dividend_i  = '0;
        bus.divisor_i   = '0;
        bus.reg_waddr_i = '0;
        rst = 1'b1;

        @(negedge clk);
        checkOutput("reset_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("reset_ready", 32'(bus.ready_o), 32'd0);
        checkOutput("reset_result", bus.result_o, 32'd0);
        checkOutput("reset_waddr", 32'(bus.reg_waddr_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic unsigned and signed cases, back-to-back.
        applyStimulus(3'b101, 32'd100, 32'd7, 5'd5, 1'b1);        waitResult(0);
        applyStimulus(3'b111, 32'd100, 32'd7, 5'd6, 1'b1);        waitResult(0);
        applyStimulus(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);  waitResult(0);
        applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1);  waitResult(0);
        applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 1'b1);  waitResult(0);
        applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 1'b1); waitResult(0);

        // Division by zero, signed and unsigned.
        applyStimulus(3'b100, 32'd5, 32'd0, 5'd11, 1'b1);          waitResult(0);
        applyStimulus(3'b111, 32'd5, 32'd0, 5'd12, 1'b1);          waitResult(0);
        applyStimulus(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd13, 1'b1);  waitResult(0);

        // Start re-pulsed with other operands while calculating.
        applyStimulus(3'b100, 32'd1000, 32'hFFFF_FFFD, 5'd14, 1'b1); waitResult(10);

        // Flush at CALC cycle 10: no ready, busy drops, result kept.
        applyStimulus(3'b101, 32'hFFFF_FFFF, 32'd3, 5'd15, 1'b0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("flush_result_kept", bus.result_o, lastResult);
        pulses = 0;
        repeat (40) begin
            if (bus.ready_o) pulses++;
            @(negedge clk);
        end
        checkOutput("flush_no_ready", 32'(pulses), 32'd0);
        applyStimulus(3'b101, 32'd9, 32'd3, 5'd16, 1'b1);          waitResult(0);

        // Flush together with start in IDLE drops the request.
        bus.start_i     = 1'b1;
        bus.flush_i     = 1'b1;
        bus.op_i        = 3'b101;
        bus.dividend_i  = 32'd50;
        bus.divisor_i   = 32'd0;
        @(posedge clk);
        #1 begin
            bus.start_i = 1'b0;
            bus.flush_i = 1'b0;
        end
        @(negedge clk);
        checkOutput("idle_flush_busy", 32'(bus.busy_o), 32'd0);
        @(negedge clk);
        checkOutput("idle_flush_no_ready", 32'(bus.ready_o), 32'd0);

        // Reset mid-operation aborts cleanly.
        applyStimulus(3'b101, 32'd1234, 32'd7, 5'd17, 1'b0);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(bus.busy_o), 32'd0);
        checkOutput("midrst_ready", 32'(bus.ready_o), 32'd0);
        checkOutput("midrst_result", bus.result_o, 32'd0);
        checkOutput("midrst_waddr", 32'(bus.reg_waddr_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lastResult = '0;
        @(negedge clk);
        applyStimulus(3'b110, 32'd1234, 32'hFFFF_FFF9, 5'd18, 1'b1); waitResult(0);

        // A few random operations across all four opcodes.
        for (int i = 0; i < 6; i++) begin
            op = 3'b100 | 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            applyStimulus(op, a, b, 5'(i + 20), 1'b1);
            waitResult(0);
        end

        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/div_engine.md
DIV_ENGINE -- requirements
Module: div_engine

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on the rising edge.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 start_i  in  1  request strobe, sampled only in IDLE.
REQ-005 dividend_i  in  32  rs1 operand.
REQ-006 divisor_i  in  32  rs2 operand.
REQ-007 op_i  in  3  funct3 code: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU.
REQ-008 reg_waddr_i  in  5  destination register index, carried with the request.
REQ-009 flush_i  in  1  cancel the in-flight operation (jump/interrupt flush).
REQ-010 busy_o  out  1  high while an operation is in flight.
REQ-011 ready_o  out  1  one-cycle pulse; result_o and reg_waddr_o are valid.
REQ-012 result_o  out  32  quotient or remainder.
REQ-013 reg_waddr_o  out  5  destination register index for the write-back.

Function
REQ-014 FSM states SHALL be IDLE, START, CALC, END, all registered; busy_o SHALL be 1 in START, CALC and END.
REQ-015 In IDLE with start_i=1 and flush_i=0, the edge SHALL latch dividend_i, divisor_i, op_i and reg_waddr_i and move to START.
REQ-016 start_i in any state other than IDLE SHALL be ignored; latched operands SHALL NOT change.
REQ-017 START with latched divisor==0: quotient SHALL be 0xFFFFFFFF and remainder SHALL be the latched dividend, then move to END (no CALC).
REQ-018 START with nonzero divisor and a signed op (DIV/REM): operands SHALL be replaced by their absolute values (two's complement; 0x80000000 maps to unsigned 2^31), then move to CALC.
REQ-019 START with nonzero divisor and an unsigned op: operands SHALL pass unchanged to CALC.
REQ-020 CALC SHALL run restoring division, one quotient bit per cycle, MSB first, using a 6-bit iteration counter.
REQ-021 CALC SHALL last exactly 32 cycles, then move to END.
REQ-022 On CALC exit, the quotient SHALL be negated when op=DIV and the operand signs differ.
REQ-023 On CALC exit, the remainder SHALL be negated when op=REM and the dividend is negative.
REQ-024 result_o SHALL be the quotient for DIV/DIVU and the remainder for REM/REMU.
REQ-025 The overflow case DIV 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000; REM of the same operands SHALL yield 0.
REQ-026 ready_o SHALL be 1 only in END, for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-027 result_o and reg_waddr_o SHALL be registered and SHALL hold their values after END until the next END.
REQ-028 Latency, counted in edges after the accepting edge: ready_o high after edge 34 for a nonzero divisor, after edge 2 for a zero divisor.
REQ-029 A new start_i SHALL be accepted in the cycle after the ready_o pulse; back-to-back operation requires no bubble beyond IDLE.
REQ-030 flush_i=1 in START, CALC or END SHALL force IDLE on the next edge.
REQ-031 On a flush, ready_o SHALL NOT pulse, result_o SHALL keep its prior value, and busy_o SHALL fall after that edge.
REQ-032 In IDLE, flush_i=1 with start_i=1 SHALL leave the FSM in IDLE: flush wins and the request is dropped.

Reset
REQ-033 rst=1 SHALL immediately force: state IDLE, busy_o=0, ready_o=0, result_o=0, reg_waddr_o=0, counter=0, all internal operand registers 0.
REQ-034 Reset asserted mid-operation SHALL abort the operation with no ready_o pulse; operation after deassertion SHALL start clean from IDLE.

Verification
REQ-035 DIVU 100/7, waddr=5: ready_o after edge 34, result_o=14 (0x0000000E), reg_waddr_o=5; REMU of the same operands gives 2.
REQ-036 REM 0xFFFFFFF9 (-7) / 2: result_o=0xFFFFFFFF (-1); DIV of the same operands gives 0xFFFFFFFD (-3).
REQ-037 DIV 0x80000000 / 0xFFFFFFFF: result_o=0x80000000; REM of the same operands gives 0x00000000.
REQ-038 DIV 5/0: ready_o after edge 2, result_o=0xFFFFFFFF; REMU 5/0 gives result_o=5 after edge 2.
REQ-039 flush_i at CALC cycle 10: busy_o=0 next cycle, no ready_o; a following DIVU 9/3 yields 3.
REQ-040 start_i re-pulsed with new operands during CALC: ignored; the original result is delivered unchanged at edge 34.
